// File: rtl/cr_kme_fifo_pkt_arb.sv
// Packet-level round-robin arbiter sharing one RAM FIFO write port among N_REQ producers.
// Ownership is held for a whole packet; a beat-count watchdog forces eop on runaway packets.
module cr_kme_fifo_pkt_arb #(
  parameter int unsigned DATA_SIZE = 10,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned TAG_W    = $clog2(N_REQ),
  localparam int unsigned FIFO_W   = DATA_SIZE + TAG_W + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]           req_eop,
  output logic [N_REQ-1:0]           req_stall,
  output logic [FIFO_W-1:0]          fifo_in,
  output logic                       fifo_in_valid,
  input  logic                       fifo_in_stall,
  output logic                       arb_busy,
  output logic [TAG_W-1:0]           arb_owner,
  output logic                       err_overrun,
  output logic                       err_overrun_sticky
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [TAG_W-1:0]     owner, rr_ptr, winner, scan_idx, owner_nxt;
  logic                 any_req;
  logic [7:0]           beat_cnt;
  logic                 own_valid, own_eop, force_eop, eop_out, accept;
  logic [DATA_SIZE-1:0] own_data;

  // Round-robin scan starting at rr_ptr, wrapping modulo N_REQ
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      scan_idx = TAG_W'((32'(rr_ptr) + 32'(i)) % N_REQ);
      if (!any_req && req_valid[scan_idx]) begin
        winner  = scan_idx;
        any_req = 1'b1;
      end
    end
  end

  // Mux the current owner's request signals
  always_comb begin
    own_valid = 1'b0;
    own_eop   = 1'b0;
    own_data  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (owner == TAG_W'(i)) begin
        own_valid = req_valid[i];
        own_eop   = req_eop[i];
        own_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOCKED;
      LOCKED:  if (accept && eop_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // fifo_in is driven to zero outside LOCKED so it stays stable while idle
  always_comb begin
    req_stall     = '1;
    fifo_in_valid = 1'b0;
    fifo_in       = '0;
    force_eop     = 1'b0;
    eop_out       = 1'b0;
    arb_busy      = 1'b0;
    if (state == LOCKED) begin
      arb_busy         = 1'b1;
      force_eop        = (beat_cnt == 8'(MAX_BEATS - 1)) && !own_eop;
      eop_out          = own_eop || force_eop;
      fifo_in_valid    = own_valid;
      fifo_in          = {owner, eop_out, own_data};
      req_stall[owner] = fifo_in_stall;
    end
  end

  assign accept    = fifo_in_valid && !fifo_in_stall;
  assign arb_owner = owner;
  assign owner_nxt = (owner == TAG_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner              <= '0;
      rr_ptr             <= '0;
      beat_cnt           <= '0;
      err_overrun        <= 1'b0;
      err_overrun_sticky <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      if (state == IDLE && any_req) begin
        owner    <= winner;
        beat_cnt <= '0;
      end else if (state == LOCKED && accept) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (eop_out) begin
          rr_ptr <= owner_nxt;
          if (force_eop) begin
            err_overrun        <= 1'b1;
            err_overrun_sticky <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_kme_fifo_pkt_arb.sv
// Directed bench for cr_kme_fifo_pkt_arb (N_REQ=4, DATA_SIZE=10, MAX_BEATS=4).
module tb_cr_kme_fifo_pkt_arb;

  localparam int unsigned DATA_SIZE = 10;
  localparam int unsigned N_REQ     = 4;
  localparam int unsigned MAX_BEATS = 4;
  localparam int unsigned TAG_W     = 2;
  localparam int unsigned FIFO_W    = DATA_SIZE + TAG_W + 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [N_REQ-1:0]           req_valid = '0;
  logic [N_REQ*DATA_SIZE-1:0] req_data = '0;
  logic [N_REQ-1:0]           req_eop = '0;
  logic [N_REQ-1:0]           req_stall;
  logic [FIFO_W-1:0]          fifo_in;
  logic                       fifo_in_valid;
  logic                       fifo_in_stall = 1'b0;
  logic                       arb_busy;
  logic [TAG_W-1:0]           arb_owner;
  logic                       err_overrun;
  logic                       err_overrun_sticky;

  int checks   = 0;
  int failures = 0;

  cr_kme_fifo_pkt_arb #(.DATA_SIZE(DATA_SIZE), .N_REQ(N_REQ), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_eop(req_eop),
    .req_stall(req_stall), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall), .arb_busy(arb_busy), .arb_owner(arb_owner),
    .err_overrun(err_overrun), .err_overrun_sticky(err_overrun_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int d, input bit e);
    req_data[i*DATA_SIZE +: DATA_SIZE] = 10'(d);
    req_eop[i] = e;
  endtask

  function automatic logic [31:0] fw(input int t, input bit e, input int d);
    logic [FIFO_W-1:0] w;
    w = {2'(t), e, 10'(d)};
    return 32'(w);
  endfunction

  int order[6] = '{0, 1, 3, 0, 1, 3};
  int bc[4];
  int o;

  initial begin
    // reset state
    mid();
    chk("rst_stall", 32'(req_stall), 32'hF);
    chk("rst_valid", 32'(fifo_in_valid), 0);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_owner", 32'(arb_owner), 0);
    chk("rst_err", 32'(err_overrun), 0);
    chk("rst_sticky", 32'(err_overrun_sticky), 0);
    next();
    rst = 1'b0;

    // single 3-beat packet from requester 2
    set_req(2, 'h11, 0); req_valid = 4'b0100;
    mid(); chk("s_arb_stall", 32'(req_stall), 32'hF); chk("s_arb_valid", 32'(fifo_in_valid), 0);
    next();
    mid(); chk("s_busy", 32'(arb_busy), 1); chk("s_owner", 32'(arb_owner), 2);
    chk("s_stall", 32'(req_stall), 32'hB); chk("s_b1", 32'(fifo_in), fw(2, 0, 'h11));
    chk("s_b1v", 32'(fifo_in_valid), 1);
    next();
    set_req(2, 'h12, 0);
    mid(); chk("s_b2", 32'(fifo_in), fw(2, 0, 'h12)); chk("s_b2v", 32'(fifo_in_valid), 1);
    next();
    set_req(2, 'h13, 1);
    mid(); chk("s_b3", 32'(fifo_in), fw(2, 1, 'h13));
    next();
    req_valid = '0; set_req(2, 0, 0);
    mid(); chk("s_idle", 32'(arb_busy), 0); chk("s_rrptr", 32'(dut.rr_ptr), 3);
    chk("s_idle_stall", 32'(req_stall), 32'hF);
    next();

    // contention: reqs 0,1,3 send 2-beat packets from reset
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bc[i] = 0;
    req_valid = 4'b1011;
    for (int k = 0; k < 18; k++) begin
      set_req(0, 'h100 + bc[0], bc[0] == 1);
      set_req(1, 'h110 + bc[1], bc[1] == 1);
      set_req(3, 'h130 + bc[3], bc[3] == 1);
      mid();
      if (k % 3 == 0) begin
        chk("c_bubble", 32'(fifo_in_valid), 0);
      end else begin
        o = order[k / 3];
        chk("c_valid", 32'(fifo_in_valid), 1);
        chk("c_word", 32'(fifo_in), fw(o, (k % 3) == 2, 'h100 + o * 16 + (k % 3) - 1));
        bc[o] = bc[o] ^ 1;
      end
      next();
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) set_req(i, 0, 0);

    // back-pressure on requester 1
    set_req(1, 'h21, 0); req_valid = 4'b0010;
    mid(); chk("b_arb", 32'(fifo_in_valid), 0);
    next();
    mid(); chk("b_stall0", 32'(req_stall), 32'hD); chk("b_b1", 32'(fifo_in), fw(1, 0, 'h21));
    next();
    set_req(1, 'h22, 0);
    mid(); chk("b_b2", 32'(fifo_in), fw(1, 0, 'h22));
    next();
    set_req(1, 'h23, 0); fifo_in_stall = 1'b1;
    repeat (3) begin
      mid();
      chk("b_stalled", 32'(req_stall), 32'hF);
      chk("b_hold", 32'(fifo_in), fw(1, 0, 'h23));
      chk("b_nowrite", 32'(dut.beat_cnt), 2);
      next();
    end
    fifo_in_stall = 1'b0;
    mid(); chk("b_unstall", 32'(req_stall), 32'hD); chk("b_b3", 32'(fifo_in), fw(1, 0, 'h23));
    next();
    set_req(1, 'h24, 1);
    mid(); chk("b_b4", 32'(fifo_in), fw(1, 1, 'h24));
    next();
    req_valid = '0; set_req(1, 0, 0);
    mid(); chk("b_idle", 32'(arb_busy), 0);
    next();

    // overrun: req 0 sends 6 beats without eop
    set_req(0, 'h41, 0); req_valid = 4'b0001;
    mid(); chk("o_arb", 32'(fifo_in_valid), 0);
    next();
    for (int b = 1; b <= 4; b++) begin
      set_req(0, 'h40 + b, 0);
      mid();
      chk("o_beat", 32'(fifo_in), fw(0, b == 4, 'h40 + b));
      chk("o_noerr", 32'(err_overrun), 0);
      next();
    end
    set_req(0, 'h45, 0);
    mid(); chk("o_pulse", 32'(err_overrun), 1); chk("o_sticky", 32'(err_overrun_sticky), 1);
    chk("o_released", 32'(arb_busy), 0);
    next();
    mid(); chk("o_pulse_end", 32'(err_overrun), 0); chk("o_regrant", 32'(arb_busy), 1);
    chk("o_b5", 32'(fifo_in), fw(0, 0, 'h45));
    next();
    set_req(0, 'h46, 1);
    mid(); chk("o_b6", 32'(fifo_in), fw(0, 1, 'h46));
    next();
    req_valid = '0; set_req(0, 0, 0);
    mid(); chk("o_idle", 32'(arb_busy), 0); chk("o_sticky_hold", 32'(err_overrun_sticky), 1);
    next();

    // reset mid-packet
    set_req(0, 'h51, 0); req_valid = 4'b0001;
    next();
    mid(); chk("r_b1", 32'(fifo_in), fw(0, 0, 'h51));
    next();
    set_req(0, 'h52, 0);
    #2 rst = 1'b1;
    #1;
    chk("r_valid", 32'(fifo_in_valid), 0);
    chk("r_stall", 32'(req_stall), 32'hF);
    chk("r_busy", 32'(arb_busy), 0);
    chk("r_sticky", 32'(err_overrun_sticky), 0);
    next();
    rst = 1'b0;
    req_valid = 4'hF;
    set_req(0, 'h61, 0);
    mid(); chk("r_arb", 32'(arb_busy), 0);
    next();
    mid(); chk("r_owner", 32'(arb_owner), 0); chk("r_granted", 32'(arb_busy), 1);
    chk("r_gstall", 32'(req_stall), 32'hE); chk("i_b1", 32'(fifo_in), fw(0, 0, 'h61));
    next();

    // owner drops valid for 5 cycles while others request
    req_valid = 4'b1110;
    repeat (5) begin
      mid();
      chk("i_nowrite", 32'(fifo_in_valid), 0);
      chk("i_busy", 32'(arb_busy), 1);
      chk("i_owner", 32'(arb_owner), 0);
      chk("i_stall", 32'(req_stall), 32'hE);
      next();
    end
    req_valid = 4'hF; set_req(0, 'h62, 0);
    mid(); chk("i_b2v", 32'(fifo_in_valid), 1); chk("i_b2", 32'(fifo_in), fw(0, 0, 'h62));
    next();
    set_req(0, 'h63, 1);
    mid(); chk("i_b3", 32'(fifo_in), fw(0, 1, 'h63));
    next();
    set_req(0, 0, 0);
    mid(); chk("i_idle", 32'(arb_busy), 0);
    next();
    mid(); chk("i_next_owner", 32'(arb_owner), 1); chk("i_next_busy", 32'(arb_busy), 1);
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
